// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register, runs a single-outstanding
// req/ack handshake with instruction memory and feeds IF/ID through a one-entry buffer.
module fetch_ctrl #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0040_0000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc,
   output logic             pc_en,
   output logic [WIDTH-1:0] npc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_inst,
   output logic [WIDTH-1:0] if_pc,
   input  logic             id_ready,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target
);

   typedef enum logic [1:0] {BOOT, FETCH, WAIT, DROP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] cpl_addr;
   logic             can_fill;
   logic             complete;
   logic             load_req;
   logic             flush;

   function automatic logic [WIDTH-1:0] inc4(input logic [WIDTH-1:0] a);
      return a + WIDTH'(4);
   endfunction

   always_comb begin
      can_fill  = !if_valid || id_ready;
      flush     = redirect_valid && (state != BOOT);
      state_nxt = state;
      pc_en     = 1'b0;
      npc       = inc4(pc);
      imem_req  = 1'b0;
      imem_addr = req_addr;
      cpl_addr  = req_addr;
      complete  = 1'b0;
      load_req  = 1'b0;

      case (state)
         BOOT: begin
            pc_en     = 1'b1;
            npc       = RESET_PC;
            state_nxt = FETCH;
         end
         FETCH: begin
            if (can_fill) begin
               imem_req  = 1'b1;
               imem_addr = pc;
               cpl_addr  = pc;
               load_req  = 1'b1;
               if (imem_ack) complete  = 1'b1;
               else          state_nxt = WAIT;
            end
         end
         WAIT: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               complete  = 1'b1;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            imem_req = 1'b1;
            if (imem_ack) state_nxt = FETCH;
         end
         default: state_nxt = BOOT;
      endcase

      if (complete) begin
         pc_en = 1'b1;
         npc   = inc4(cpl_addr);
      end

      // A redirect wins over any completion; a still-pending request must be drained in DROP.
      if (flush) begin
         pc_en     = 1'b1;
         npc       = redirect_target;
         complete  = 1'b0;
         state_nxt = (imem_req && !imem_ack) ? DROP : FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= BOOT;
         req_addr <= '0;
      end else begin
         state <= state_nxt;
         if (load_req) req_addr <= pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_valid <= 1'b0;
         if_inst  <= '0;
         if_pc    <= '0;
      end else if (flush) begin
         if_valid <= 1'b0;
      end else if (complete) begin
         if_valid <= 1'b1;
         if_inst  <= imem_rdata;
         if_pc    <= cpl_addr;
      end else if (if_valid && id_ready) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC register and variable-latency memory models,
// scoreboard of expected deliveries checked by an independent monitor.
module tb_fetch_ctrl;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sb_e;
   int          lat = 1;
   int          cnt;

   fetch_ctrl #(.WIDTH(32), .RESET_PC(RPC)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .pc_en          (pc_en),
      .npc            (npc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // PC register model
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       pc <= '0;
      else if (pc_en) pc <= npc;
   end

   // Memory model: ack after `lat` cycles of continuous request
   assign imem_ack   = imem_req && (cnt >= lat - 1);
   assign imem_rdata = inst_of(imem_addr);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      cnt <= 0;
      else if (imem_req && !imem_ack) cnt <= cnt + 1;
      else                            cnt <= 0;
   end

   // Monitor: every delivery accepted by IF/ID must match the scoreboard head
   always @(negedge clk) begin
      if (rst === 1'b1 && if_valid && id_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got if_pc %h, expected no delivery", if_pc);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_pc", if_pc, sb_e);
            chk("sb_inst", if_inst, inst_of(sb_e));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no completion, expected finish before 50000");
      $fatal(1, "watchdog");
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_pc_en", pc_en, 1);    chk("rst_npc", npc, RPC);
      chk("rst_req", imem_req, 0);   chk("rst_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);    chk("rst_if_inst", if_inst, 0);

      // zero-wait stream
      exp_q.push_back(32'h0040_0000);
      exp_q.push_back(32'h0040_0004);
      nxt(); rst = 1'b1; smp();                                   // cycle 0
      chk("c0_pc_en", pc_en, 1); chk("c0_npc", npc, RPC); chk("c0_req", imem_req, 0);
      nxt(); smp();                                               // cycle 1
      chk("c1_req", imem_req, 1); chk("c1_addr", imem_addr, RPC);
      chk("c1_valid", if_valid, 0); chk("c1_npc", npc, 32'h0040_0004);
      nxt(); smp();                                               // cycle 2
      chk("c2_valid", if_valid, 1); chk("c2_if_pc", if_pc, 32'h0040_0000);
      chk("c2_addr", imem_addr, 32'h0040_0004);
      nxt(); smp();                                               // cycle 3
      chk("c3_valid", if_valid, 1); chk("c3_if_pc", if_pc, 32'h0040_0004);
      chk("c3_addr", imem_addr, 32'h0040_0008);

      // back-pressure
      nxt(); id_ready = 1'b0; exp_q.push_back(32'h0040_0008); smp();   // cycle 4
      chk("c4_valid", if_valid, 1); chk("c4_if_pc", if_pc, 32'h0040_0008);
      chk("c4_req", imem_req, 0);
      for (int i = 0; i < 3; i++) begin                           // cycles 5-7
         nxt(); smp();
         chk("stall_req", imem_req, 0); chk("stall_if_pc", if_pc, 32'h0040_0008);
         chk("stall_if_inst", if_inst, inst_of(32'h0040_0008)); chk("stall_pc_en", pc_en, 0);
      end

      // 3-cycle memory
      nxt(); id_ready = 1'b1; lat = 3;
      exp_q.push_back(32'h0040_000C); exp_q.push_back(32'h0040_0010); smp();   // cycle 8
      chk("c8_req", imem_req, 1); chk("c8_addr", imem_addr, 32'h0040_000C); chk("c8_pc_en", pc_en, 0);
      nxt(); smp();                                               // cycle 9
      chk("c9_addr", imem_addr, 32'h0040_000C); chk("c9_pc_en", pc_en, 0); chk("c9_valid", if_valid, 0);
      nxt(); smp();                                               // cycle 10
      chk("c10_addr", imem_addr, 32'h0040_000C); chk("c10_ack", imem_ack, 1);
      chk("c10_pc_en", pc_en, 1); chk("c10_npc", npc, 32'h0040_0010);
      nxt(); smp();                                               // cycle 11
      chk("c11_valid", if_valid, 1); chk("c11_addr", imem_addr, 32'h0040_0010);
      nxt(); smp();                                               // cycle 12
      chk("c12_valid", if_valid, 0); chk("c12_pc", pc, 32'h0040_0010);
      nxt(); smp();                                               // cycle 13
      chk("c13_valid", if_valid, 0);
      nxt(); smp();                                               // cycle 14
      chk("c14_valid", if_valid, 1); chk("c14_addr", imem_addr, 32'h0040_0014);

      // redirect while waiting: pending ack must be discarded
      nxt(); redirect_valid = 1'b1; redirect_target = 32'h0040_0100; smp();   // cycle 15
      chk("c15_pc_en", pc_en, 1); chk("c15_npc", npc, 32'h0040_0100);
      chk("c15_req", imem_req, 1); chk("c15_addr", imem_addr, 32'h0040_0014);
      nxt(); redirect_valid = 1'b0; smp();                        // cycle 16
      chk("c16_valid", if_valid, 0); chk("c16_req", imem_req, 1);
      chk("c16_addr", imem_addr, 32'h0040_0014); chk("c16_ack", imem_ack, 1);
      chk("c16_pc_en", pc_en, 0); chk("c16_pc", pc, 32'h0040_0100);
      nxt(); lat = 1; smp();                                      // cycle 17
      chk("c17_valid", if_valid, 0); chk("c17_req", imem_req, 1);
      chk("c17_addr", imem_addr, 32'h0040_0100);

      // redirect flushes a full buffer
      nxt(); id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; smp();   // cycle 18
      chk("c18_valid", if_valid, 1); chk("c18_if_pc", if_pc, 32'h0040_0100);
      chk("c18_req", imem_req, 0); chk("c18_pc_en", pc_en, 1); chk("c18_npc", npc, 32'hFFFF_FFFC);

      // address wrap
      nxt(); redirect_valid = 1'b0; id_ready = 1'b1; exp_q.push_back(32'hFFFF_FFFC); smp();   // cycle 19
      chk("c19_valid", if_valid, 0); chk("c19_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc_en", pc_en, 1); chk("wrap_npc", npc, 32'h0000_0000);

      // redirect coinciding with ack
      nxt(); redirect_valid = 1'b1; redirect_target = 32'h0040_0200; smp();   // cycle 20
      chk("c20_addr", imem_addr, 32'h0000_0000); chk("c20_ack", imem_ack, 1);
      chk("c20_pc_en", pc_en, 1); chk("c20_npc", npc, 32'h0040_0200);
      nxt(); redirect_valid = 1'b0; smp();                        // cycle 21
      chk("c21_valid", if_valid, 0); chk("c21_pc", pc, 32'h0040_0200);
      chk("c21_addr", imem_addr, 32'h0040_0200);
      nxt(); id_ready = 1'b0; smp();                              // cycle 22
      chk("c22_valid", if_valid, 1); chk("c22_if_pc", if_pc, 32'h0040_0200); chk("c22_req", imem_req, 0);

      // reset in the middle of a request
      nxt(); id_ready = 1'b1; lat = 3; #2;
      chk("c23_req", imem_req, 1); chk("c23_addr", imem_addr, 32'h0040_0204);
      rst = 1'b0; #1;
      chk("arst_req", imem_req, 0); chk("arst_pc_en", pc_en, 1);
      chk("arst_npc", npc, RPC); chk("arst_valid", if_valid, 0); chk("arst_if_pc", if_pc, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
